// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle between the AES round sequencer, the command side and the
// round-key expander / round datapath pair. The slave modport is the
// sequencer itself; the master modport is everything that talks to it.
interface aes_round_sequencer_if;
    logic       start;
    logic       key_rdy;
    logic       round_done;
    logic       encrypt_en;
    logic       key_req;
    logic [3:0] key_sel;
    logic       key_load;
    logic       round_start;
    logic [1:0] round_type;
    logic       busy;
    logic       done;
    logic       key_err;

    modport master (
        output start, key_rdy, round_done,
        input  encrypt_en, key_req, key_sel, key_load, round_start,
               round_type, busy, done, key_err
    );

    modport slave (
        input  start, key_rdy, round_done,
        output encrypt_en, key_req, key_sel, key_load, round_start,
               round_type, busy, done, key_err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for one AES-128 block: enables the key expander, fetches round
// keys 0..NUM_ROUNDS one at a time, launches one datapath round per key and
// reports completion or a key-fetch timeout. Every output is a register.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    aes_round_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_RND = 2'd2;
    localparam logic [1:0] S_FIN      = 2'd3;

    localparam logic [1:0] RT_INITIAL = 2'd0;
    localparam logic [1:0] RT_FULL    = 2'd1;
    localparam logic [1:0] RT_FINAL   = 2'd2;

    localparam logic [3:0] LAST_ROUND   = 4'(NUM_ROUNDS);
    localparam logic [6:0] TIMEOUT_LAST = 7'(KEY_TIMEOUT - 1);
    localparam logic [6:0] TIMEOUT_MAX  = 7'(KEY_TIMEOUT);

    logic [1:0] r_state;
    logic [3:0] r_roundCnt;
    logic [6:0] r_waitCnt;
    logic       r_encryptEn;
    logic       r_keyReq;
    logic       r_keyLoad;
    logic       r_roundStart;
    logic [1:0] r_roundType;
    logic       r_busy;
    logic       r_done;
    logic       r_keyErr;

    logic       w_lastRound;
    logic       w_timeout;
    logic [1:0] w_nextType;
    logic [3:0] w_nextCnt;

    // Round-type decode and next-round/timeout conditions for the FSM.
    always_comb begin
        w_lastRound = (r_roundCnt == LAST_ROUND);
        w_timeout   = (r_waitCnt >= TIMEOUT_LAST);
        w_nextCnt   = r_roundCnt + 4'd1;
        w_nextType  = RT_FULL;
        if (r_roundCnt == 4'd0) begin
            w_nextType = RT_INITIAL;
        end else if (w_lastRound) begin
            w_nextType = RT_FINAL;
        end
    end

    // Sequencer FSM; busy and encrypt_en already drop on entry to FIN so they
    // fall together with the done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_roundCnt   <= 4'd0;
            r_waitCnt    <= 7'd0;
            r_encryptEn  <= 1'b0;
            r_keyReq     <= 1'b0;
            r_keyLoad    <= 1'b0;
            r_roundStart <= 1'b0;
            r_roundType  <= RT_INITIAL;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keyErr     <= 1'b0;
        end else begin
            r_keyLoad    <= 1'b0;
            r_roundStart <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_REQ;
                        r_roundCnt  <= 4'd0;
                        r_waitCnt   <= 7'd0;
                        r_keyErr    <= 1'b0;
                        r_encryptEn <= 1'b1;
                        r_busy      <= 1'b1;
                        r_keyReq    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.key_rdy) begin
                        // key_req stays high this cycle so the expander
                        // keeps round_key stable while key_load is asserted
                        r_keyLoad    <= 1'b1;
                        r_roundStart <= 1'b1;
                        r_roundType  <= w_nextType;
                        r_state      <= S_WAIT_RND;
                    end else if (w_timeout) begin
                        r_keyErr    <= 1'b1;
                        r_encryptEn <= 1'b0;
                        r_busy      <= 1'b0;
                        r_keyReq    <= 1'b0;
                        r_waitCnt   <= TIMEOUT_MAX;
                        r_state     <= S_IDLE;
                    end else if (r_waitCnt != TIMEOUT_MAX) begin
                        r_waitCnt <= r_waitCnt + 7'd1;
                    end
                end
                S_WAIT_RND: begin
                    if (bus.round_done) begin
                        if (w_lastRound) begin
                            r_keyReq    <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_encryptEn <= 1'b0;
                            r_state     <= S_FIN;
                        end else begin
                            r_roundCnt <= w_nextCnt;
                            r_waitCnt  <= 7'd0;
                            r_keyReq   <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end else begin
                        r_keyReq <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.encrypt_en  = r_encryptEn;
    assign bus.key_req     = r_keyReq;
    assign bus.key_sel     = r_roundCnt;
    assign bus.key_load    = r_keyLoad;
    assign bus.round_start = r_roundStart;
    assign bus.round_type  = r_roundType;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.key_err     = r_keyErr;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: stimulus pushes the expected round
// records and done pulses, a negedge monitor pops and compares them, and
// behavioural expander/datapath models answer the handshakes.
module tb_aes_round_sequencer;

    localparam int NUM_ROUNDS  = 10;
    localparam int KEY_TIMEOUT = 64;

    typedef struct {
        logic [3:0] sel;
        logic [1:0] rtype;
    } roundExp_t;

    logic clk = 1'b0;
    logic resetn;

    logic modelKeyRdy    = 1'b0;
    logic spurKeyRdy     = 1'b0;
    logic modelRoundDone = 1'b0;
    logic spurRoundDone  = 1'b0;
    int   expMode        = 0;

    int   checkCount   = 0;
    int   passCount    = 0;
    int   expDoneCount = 0;
    int   doneSeen     = 0;

    roundExp_t  expRounds[$];
    logic [1:0] typeTable [11];

    aes_round_sequencer_if bus();

    assign bus.key_rdy    = modelKeyRdy | spurKeyRdy;
    assign bus.round_done = modelRoundDone | spurRoundDone;

    aes_round_sequencer #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .KEY_TIMEOUT(KEY_TIMEOUT)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".encrypt_en"},  32'(bus.encrypt_en),  0);
        checkOutput({tag, ".key_req"},     32'(bus.key_req),     0);
        checkOutput({tag, ".key_sel"},     32'(bus.key_sel),     0);
        checkOutput({tag, ".key_load"},    32'(bus.key_load),    0);
        checkOutput({tag, ".round_start"}, 32'(bus.round_start), 0);
        checkOutput({tag, ".round_type"},  32'(bus.round_type),  0);
        checkOutput({tag, ".busy"},        32'(bus.busy),        0);
        checkOutput({tag, ".done"},        32'(bus.done),        0);
        checkOutput({tag, ".key_err"},     32'(bus.key_err),     0);
    endtask

    task automatic pushBlock();
        roundExp_t e;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            e.sel   = 4'(i);
            e.rtype = typeTable[i];
            expRounds.push_back(e);
        end
        expDoneCount++;
    endtask

    // One-cycle start pulse, issued just after a rising edge.
    task automatic applyStimulus(input bit expectBlock);
        if (expectBlock) pushBlock();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic waitForDone(input string name, input int budget);
        int base;
        int n;
        base = doneSeen;
        n    = 0;
        while (doneSeen == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, 32'(doneSeen != base), 1);
    endtask

    task automatic waitForLoad(input string name, input logic [3:0] sel, input int budget);
        int n;
        n = 0;
        while (!(bus.key_load && bus.key_sel == sel) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(bus.key_load && bus.key_sel == sel), 1);
    endtask

    task automatic checkAccepted(input string tag);
        checkOutput({tag, ".busy"},       32'(bus.busy),       1);
        checkOutput({tag, ".encrypt_en"}, 32'(bus.encrypt_en), 1);
        checkOutput({tag, ".key_req"},    32'(bus.key_req),    1);
        checkOutput({tag, ".key_sel"},    32'(bus.key_sel),    0);
        checkOutput({tag, ".key_err"},    32'(bus.key_err),    0);
    endtask

    // Expander model: answers each key request after a mode-dependent delay
    // counted from the first cycle key_req is seen high.
    initial begin : expanderModel
        bit inWait;
        int age;
        int delay;
        inWait = 1'b0;
        age    = 0;
        delay  = 0;
        forever begin
            @(posedge clk); #1;
            modelKeyRdy = 1'b0;
            if (!resetn || !bus.key_req || bus.key_load) begin
                inWait = 1'b0;
            end else begin
                if (!inWait) begin
                    inWait = 1'b1;
                    age    = 0;
                    if (expMode == 2) delay = -1;
                    else if (expMode == 1) delay = int'($urandom_range(1, 40));
                    else delay = (bus.key_sel == 4'd0) ? 25 : 1;
                end else begin
                    age++;
                end
                if (age == delay) modelKeyRdy = 1'b1;
            end
        end
    end

    // Datapath model: round_done pulses three cycles after round_start.
    initial begin : datapathModel
        int rdCnt;
        rdCnt = 0;
        forever begin
            @(posedge clk); #1;
            modelRoundDone = 1'b0;
            if (!resetn) begin
                rdCnt = 0;
            end else if (bus.round_start) begin
                rdCnt = 3;
            end else if (rdCnt > 0) begin
                rdCnt--;
                if (rdCnt == 0) modelRoundDone = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on round_start and done, and checks that
    // pending key requests stay stable on the expected key index.
    initial begin : monitor
        roundExp_t e;
        bit holdPrev;
        holdPrev = 1'b0;
        forever begin
            @(negedge clk);
            if (holdPrev && resetn && !bus.key_err) begin
                checkOutput("keyReqHeld", 32'(bus.key_req), 1);
            end
            if (resetn && bus.key_req && !bus.key_load && expRounds.size() > 0) begin
                checkOutput("keySelInReq", 32'(bus.key_sel), 32'(expRounds[0].sel));
            end
            holdPrev = resetn && bus.key_req && !bus.key_rdy && !bus.key_load;

            if (bus.key_load || bus.round_start) begin
                checkOutput("loadStartPaired", 32'(bus.key_load), 32'(bus.round_start));
            end
            if (bus.round_start) begin
                checkOutput("keyReqHeldDuringLoad", 32'(bus.key_req), 1);
                checkOutput("roundExpected", 32'(expRounds.size() != 0), 1);
                if (expRounds.size() != 0) begin
                    e = expRounds.pop_front();
                    checkOutput("roundKeySel", 32'(bus.key_sel), 32'(e.sel));
                    checkOutput("roundType", 32'(bus.round_type), 32'(e.rtype));
                end
            end
            if (bus.done) begin
                checkOutput("doneExpected", 32'(expDoneCount > 0), 1);
                if (expDoneCount > 0) expDoneCount--;
                checkOutput("encryptEnLowAtDone", 32'(bus.encrypt_en), 0);
                checkOutput("busyLowAtDone", 32'(bus.busy), 0);
                doneSeen++;
            end
        end
    end

    // Directed test sequence.
    initial begin : stimulus
        int n;
        typeTable = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        bus.start = 1'b0;
        resetn    = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] nominal block");
        expMode = 0;
        applyStimulus(1'b1);
        checkAccepted("nominalAccept");
        waitForDone("nominalDone", 2000);
        @(posedge clk); #1;
        checkOutput("nominalEncryptEnAfter", 32'(bus.encrypt_en), 0);
        checkOutput("nominalBusyAfter", 32'(bus.busy), 0);
        checkOutput("nominalRoundsLeft", 32'(expRounds.size()), 0);
        checkOutput("nominalDoneLeft", 32'(expDoneCount), 0);

        $display("[TB] key timeout");
        expMode = 2;
        applyStimulus(1'b0);
        checkOutput("timeoutReqRise", 32'(bus.key_req), 1);
        n = 0;
        while (!bus.key_err && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeoutLatency", 32'(n), 32'(KEY_TIMEOUT));
        checkOutput("timeoutKeyReq", 32'(bus.key_req), 0);
        checkOutput("timeoutBusy", 32'(bus.busy), 0);
        checkOutput("timeoutEncryptEn", 32'(bus.encrypt_en), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("timeoutErrSticky", 32'(bus.key_err), 1);
        expMode = 0;
        applyStimulus(1'b1);
        checkAccepted("restartAfterTimeout");
        waitForDone("restartDone", 2000);

        $display("[TB] ignored events");
        @(posedge clk); #1;
        applyStimulus(1'b1);
        waitForLoad("ignReachRound3", 4'd3, 500);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        spurKeyRdy = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        spurKeyRdy = 1'b0;
        checkOutput("ignBusy", 32'(bus.busy), 1);
        checkOutput("ignKeyReqLow", 32'(bus.key_req), 0);
        checkOutput("ignKeySel", 32'(bus.key_sel), 3);
        n = 0;
        while (!(bus.key_req && !bus.key_load) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ignNextReqSel", 32'(bus.key_sel), 4);
        spurRoundDone = 1'b1;
        @(posedge clk); #1;
        spurRoundDone = 1'b0;
        waitForDone("ignDone", 2000);
        checkOutput("ignRoundsLeft", 32'(expRounds.size()), 0);

        $display("[TB] reset mid-run");
        @(posedge clk); #1;
        applyStimulus(1'b1);
        waitForLoad("rstReachRound5", 4'd5, 500);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        checkResetOutputs("midReset");
        checkOutput("rstRoundsLeft", 32'(expRounds.size()), 5);
        checkOutput("rstDoneLeft", 32'(expDoneCount), 1);
        expRounds.delete();
        expDoneCount = 0;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1);
        checkAccepted("rstRestart");
        waitForDone("rstRestartDone", 2000);

        $display("[TB] back-to-back blocks");
        @(posedge clk); #1;
        applyStimulus(1'b1);
        n = 0;
        while (!bus.done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("b2bSawDone", 32'(bus.done), 1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2bStartInFinIgnored", 32'(bus.busy), 0);
        checkOutput("b2bEncryptEnGap", 32'(bus.encrypt_en), 0);
        pushBlock();
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkAccepted("b2bSecondAccept");
        waitForDone("b2bDone", 2000);
        checkOutput("b2bRoundsLeft", 32'(expRounds.size()), 0);

        $display("[TB] random key delays");
        @(posedge clk); #1;
        expMode = 1;
        applyStimulus(1'b1);
        waitForDone("holdDone", 3000);
        checkOutput("holdRoundsLeft", 32'(expRounds.size()), 0);
        checkOutput("holdDoneLeft", 32'(expDoneCount), 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
